rr_arbiter_mux: RTL and testbench

- Parametrised N-master to 1-slave packet multiplexer for the DSP controller bus; successor to the fixed 16:1 combinational select mux.
- Adds a built-in round-robin arbiter, per-master valid/ready handshake, grant lock for the length of a packet (held until IN_LAST), and a registered output stage.
- Sits between the master ports (DSP cores and host interface) and the single shared slave or controller input.

---
 rtl/rr_arbiter_mux_pkg.sv | 19 +
 rtl/rr_arbiter_mux_if.sv | 31 +++
 rtl/rr_priority_pick.sv | 37 +++
 rtl/rr_arbiter_mux.sv | 123 ++++++++++++
 tb/tb_rr_arbiter_mux.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_mux_pkg.sv
// Shared definitions for the round-robin arbitrating packet mux: FSM state
// encodings and the helper that derives the grant index width.
package rr_arbiter_mux_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    // Ceiling log2 with a floor of 1, so a single-master build still gets a 1-bit index.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r = 0;
        while (r < 31 && (32'd1 << r) < n) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter_mux_if.sv
// Bus bundle between the N master ports, the arbitrating mux and the shared slave.
// The slave modport is the mux's view; the master modport is the environment's view.
interface rr_arbiter_mux_if
    import rr_arbiter_mux_pkg::*;
#(
    parameter int unsigned NumOfInput   = 16,
    parameter int unsigned NumOfSelBits = clog2(NumOfInput),
    parameter int unsigned DataWidth    = 16
);
    logic [NumOfInput-1:0]           in_valid;
    logic [NumOfInput*DataWidth-1:0] in_data;
    logic [NumOfInput-1:0]           in_last;
    logic [NumOfInput-1:0]           in_ready;
    logic                            out_valid;
    logic [DataWidth-1:0]            out_data;
    logic                            out_last;
    logic                            out_ready;
    logic [NumOfSelBits-1:0]         sel;
    logic                            grant_active;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, sel, grant_active
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, sel, grant_active
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr_i,
// wrapping modulo NumOfInput, via a double-width masked priority encoder.
module rr_priority_pick
    import rr_arbiter_mux_pkg::*;
#(
    parameter int unsigned NumOfInput   = 16,
    parameter int unsigned NumOfSelBits = clog2(NumOfInput)
) (
    input  logic [NumOfInput-1:0]   req_i,
    input  logic [NumOfSelBits-1:0] ptr_i,
    output logic                    found_o,
    output logic [NumOfSelBits-1:0] idx_o
);
    localparam int N = int'(NumOfInput);

    logic [2*N-1:0] req_masked;

    // Lower copy keeps only indices >= ptr; the upper copy supplies the wrapped candidates.
    always_comb begin
        for (int j = 0; j < 2 * N; j++) begin
            req_masked[j] = req_i[j % N] && ((j >= N) || (j >= int'(ptr_i)));
        end
    end

    // Lowest set bit of the masked vector wins; scanning downward lets the lowest overwrite.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int j = 2 * N - 1; j >= 0; j--) begin
            if (req_masked[j]) begin
                found_o = 1'b1;
                idx_o   = NumOfSelBits'((j >= N) ? (j - N) : j);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_mux.sv
// N-master to 1-slave packet mux with round-robin arbitration, grant lock until
// end-of-packet, per-master valid/ready and a registered output stage.
module rr_arbiter_mux
    import rr_arbiter_mux_pkg::*;
#(
    parameter int unsigned NumOfInput   = 16,
    parameter int unsigned NumOfSelBits = clog2(NumOfInput),
    parameter int unsigned DataWidth    = 16
) (
    input logic             clk_i,
    input logic             rst_ni,
    rr_arbiter_mux_if.slave bus_io
);
    localparam int N = int'(NumOfInput);

    state_e                  state_q, state_d;
    logic [NumOfSelBits-1:0] ptr_q, ptr_d;
    logic [NumOfSelBits-1:0] sel_q, sel_d;
    logic                    out_valid_q, out_valid_d;
    logic [DataWidth-1:0]    out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;

    logic                    pick_found;
    logic [NumOfSelBits-1:0] pick_idx;
    logic                    cur_valid;
    logic                    cur_last;
    logic [DataWidth-1:0]    cur_data;
    logic                    can_accept;
    logic                    xfer;
    logic [NumOfInput-1:0]   in_ready;

    rr_priority_pick #(
        .NumOfInput  (NumOfInput),
        .NumOfSelBits(NumOfSelBits)
    ) u_pick (
        .req_i  (bus_io.in_valid),
        .ptr_i  (ptr_q),
        .found_o(pick_found),
        .idx_o  (pick_idx)
    );

    assign can_accept = !out_valid_q || bus_io.out_ready;
    assign xfer       = (state_q == StGrant) && cur_valid && can_accept;

    // Route the granted master's signals; compare-per-index keeps select widths exact.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(sel_q) == i) begin
                cur_valid   = bus_io.in_valid[i];
                cur_last    = bus_io.in_last[i];
                cur_data    = bus_io.in_data[i*DataWidth +: DataWidth];
                in_ready[i] = (state_q == StGrant) && can_accept;
            end
        end
    end

    // Arbitrate in IDLE, hold the grant until the last beat is transferred.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (xfer && cur_last) begin
                    state_d = StIdle;
                    ptr_d   = (int'(sel_q) == N - 1) ? '0 : sel_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output stage: load on transfer, drain on downstream accept, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = cur_data;
            out_last_d  = cur_last;
        end else if (bus_io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus_io.in_ready     = in_ready;
    assign bus_io.out_valid    = out_valid_q;
    assign bus_io.out_data     = out_data_q;
    assign bus_io.out_last     = out_last_q;
    assign bus_io.sel          = sel_q;
    assign bus_io.grant_active = (state_q == StGrant);

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Self-checking bench: table-driven vectors for the priority pick, then directed
// sequences for the 16-master and 5-master mux builds.
module tb_rr_arbiter_mux;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rr_arbiter_mux_if #(.NumOfInput(16), .NumOfSelBits(4), .DataWidth(16)) b16 ();
    rr_arbiter_mux_if #(.NumOfInput(5),  .NumOfSelBits(3), .DataWidth(16)) b5 ();

    rr_arbiter_mux #(.NumOfInput(16), .NumOfSelBits(4), .DataWidth(16)) dut16 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(b16)
    );

    rr_arbiter_mux #(.NumOfInput(5), .NumOfSelBits(3), .DataWidth(16)) dut5 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(b5)
    );

    logic [15:0] pk_req;
    logic [3:0]  pk_ptr;
    logic        pk_found;
    logic [3:0]  pk_idx;

    rr_priority_pick #(.NumOfInput(16), .NumOfSelBits(4)) u_pick (
        .req_i  (pk_req),
        .ptr_i  (pk_ptr),
        .found_o(pk_found),
        .idx_o  (pk_idx)
    );

    typedef struct {
        logic [15:0] req;
        logic [3:0]  ptr;
        logic        found;
        logic [3:0]  idx;
    } pick_vec_t;

    pick_vec_t pv[10];

    // Output beats accepted downstream during the backpressure sequence.
    logic [15:0] mon_q[$];
    logic        mon_en = 1'b0;

    always @(posedge clk) begin
        if (mon_en && b16.out_valid && b16.out_ready) mon_q.push_back(b16.out_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input int i, input logic v, input logic [15:0] d, input logic l);
        b16.in_valid[i]          = v;
        b16.in_data[i*16 +: 16]  = d;
        b16.in_last[i]           = l;
    endtask

    task automatic drive5(input int i, input logic v, input logic [15:0] d, input logic l);
        b5.in_valid[i]          = v;
        b5.in_data[i*16 +: 16]  = d;
        b5.in_last[i]           = l;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rr_exp[5];
        int          np_exp[4];
        int          bk;
        int          stall_cnt;
        logic        hs;
        logic        prev_stall;
        logic [15:0] prev_data;

        rst_n         = 1'b0;
        b16.in_valid  = '0;
        b16.in_data   = '0;
        b16.in_last   = '0;
        b16.out_ready = 1'b1;
        b5.in_valid   = '0;
        b5.in_data    = '0;
        b5.in_last    = '0;
        b5.out_ready  = 1'b1;

        pv[0] = '{16'h0000, 4'd0,  1'b0, 4'd0};
        pv[1] = '{16'h0008, 4'd0,  1'b1, 4'd3};
        pv[2] = '{16'h0008, 4'd4,  1'b1, 4'd3};
        pv[3] = '{16'h8021, 4'd0,  1'b1, 4'd0};
        pv[4] = '{16'h8021, 4'd1,  1'b1, 4'd5};
        pv[5] = '{16'h8021, 4'd6,  1'b1, 4'd15};
        pv[6] = '{16'h0001, 4'd15, 1'b1, 4'd0};
        pv[7] = '{16'hFFFF, 4'd9,  1'b1, 4'd9};
        pv[8] = '{16'h0100, 4'd9,  1'b1, 4'd8};
        pv[9] = '{16'h8000, 4'd15, 1'b1, 4'd15};

        for (int k = 0; k < 10; k++) begin
            pk_req = pv[k].req;
            pk_ptr = pv[k].ptr;
            #1;
            chk($sformatf("pick%0d_found", k), 32'(pk_found), 32'(pv[k].found));
            chk($sformatf("pick%0d_idx", k), 32'(pk_idx), 32'(pv[k].idx));
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", 32'(b16.sel), 0);
        chk("rst_grant", 32'(b16.grant_active), 0);
        chk("rst_in_ready", 32'(b16.in_ready), 0);
        chk("rst_out_valid", 32'(b16.out_valid), 0);
        chk("rst_out_data", 32'(b16.out_data), 0);
        chk("rst_out_last", 32'(b16.out_last), 0);
        rst_n = 1'b1;

        // Single master, 3-beat packet
        drive16(3, 1'b1, 16'h00A1, 1'b0);
        tick();
        chk("single_sel", 32'(b16.sel), 3);
        chk("single_grant", 32'(b16.grant_active), 1);
        chk("single_in_ready", 32'(b16.in_ready), 'h0008);
        chk("single_no_out_yet", 32'(b16.out_valid), 0);
        tick();
        chk("single_b1_valid", 32'(b16.out_valid), 1);
        chk("single_b1_data", 32'(b16.out_data), 'hA1);
        chk("single_b1_last", 32'(b16.out_last), 0);
        drive16(3, 1'b1, 16'h00A2, 1'b0);
        tick();
        chk("single_b2_data", 32'(b16.out_data), 'hA2);
        drive16(3, 1'b1, 16'h00A3, 1'b1);
        tick();
        chk("single_b3_data", 32'(b16.out_data), 'hA3);
        chk("single_b3_last", 32'(b16.out_last), 1);
        chk("single_grant_fall", 32'(b16.grant_active), 0);
        drive16(3, 1'b0, 16'h0000, 1'b0);
        tick();
        chk("single_drained", 32'(b16.out_valid), 0);

        // Round robin among masters 0, 5, 15 with 1-beat packets
        do_reset();
        drive16(0,  1'b1, 16'h0100, 1'b1);
        drive16(5,  1'b1, 16'h0105, 1'b1);
        drive16(15, 1'b1, 16'h010F, 1'b1);
        rr_exp = '{0, 5, 15, 0, 5};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr%0d_sel", k), 32'(b16.sel), 32'(rr_exp[k]));
            chk($sformatf("rr%0d_grant", k), 32'(b16.grant_active), 1);
            chk($sformatf("rr%0d_in_ready", k), 32'(b16.in_ready), 32'd1 << rr_exp[k]);
            tick();
            chk($sformatf("rr%0d_bubble", k), 32'(b16.grant_active), 0);
            chk($sformatf("rr%0d_data", k), 32'(b16.out_data), 32'('h100 + rr_exp[k]));
        end
        b16.in_valid = '0;
        b16.in_last  = '0;
        tick();

        // Backpressure: master 9, 4 beats, OUT_READY low for 4 cycles mid-packet
        mon_q.delete();
        mon_en     = 1'b1;
        bk         = 0;
        stall_cnt  = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 30 && bk < 4; c++) begin
            b16.out_ready = !(c >= 3 && c < 7);
            drive16(9, 1'b1, 16'(16'hB0 + bk), bk == 3);
            @(negedge clk);
            hs = b16.in_valid[9] && b16.in_ready[9];
            if (b16.out_valid && !b16.out_ready) begin
                stall_cnt++;
                chk("bp_in_ready_low", 32'(b16.in_ready), 0);
                if (prev_stall) chk("bp_data_hold", 32'(b16.out_data), 32'(prev_data));
                prev_stall = 1'b1;
                prev_data  = b16.out_data;
            end else begin
                prev_stall = 1'b0;
            end
            @(posedge clk);
            #1;
            if (hs) bk++;
        end
        chk("bp_all_accepted", 32'(bk), 4);
        chk("bp_stall_cycles", 32'(stall_cnt), 4);
        drive16(9, 1'b0, 16'h0000, 1'b0);
        b16.out_ready = 1'b1;
        repeat (3) tick();
        mon_en = 1'b0;
        chk("bp_beat_count", 32'(mon_q.size()), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_beat%0d", i),
                (i < mon_q.size()) ? 32'(mon_q[i]) : 32'hDEAD, 32'('hB0 + i));
        end

        // Grant lock: master 2 stalls mid-packet while master 7 requests
        drive16(2, 1'b1, 16'h00C0, 1'b0);
        tick();
        chk("lock_sel", 32'(b16.sel), 2);
        tick();
        chk("lock_b1_data", 32'(b16.out_data), 'hC0);
        drive16(2, 1'b0, 16'h00C1, 1'b0);
        drive16(7, 1'b1, 16'h0077, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("lock%0d_sel", k), 32'(b16.sel), 2);
            chk($sformatf("lock%0d_grant", k), 32'(b16.grant_active), 1);
            chk($sformatf("lock%0d_in_ready", k), 32'(b16.in_ready), 'h0004);
            chk($sformatf("lock%0d_no_out", k), 32'(b16.out_valid), 0);
        end
        drive16(2, 1'b1, 16'h00C1, 1'b1);
        tick();
        chk("lock_last_data", 32'(b16.out_data), 'hC1);
        chk("lock_last_flag", 32'(b16.out_last), 1);
        chk("lock_released", 32'(b16.grant_active), 0);
        drive16(2, 1'b0, 16'h0000, 1'b0);
        tick();
        chk("lock_next_sel", 32'(b16.sel), 7);
        tick();
        chk("lock_next_data", 32'(b16.out_data), 'h77);
        drive16(7, 1'b0, 16'h0000, 1'b0);
        tick();

        // Non-power-of-two build: master 4 finishes, pointer wraps to 0
        drive5(4, 1'b1, 16'h0054, 1'b1);
        np_exp = '{4, 0, 1, 4};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("np2_%0d_sel", k), 32'(b5.sel), 32'(np_exp[k]));
            chk($sformatf("np2_%0d_range", k), 32'(b5.sel < 3'd5), 1);
            if (k == 0) begin
                drive5(0, 1'b1, 16'h0050, 1'b1);
                drive5(1, 1'b1, 16'h0051, 1'b1);
            end
            tick();
            chk($sformatf("np2_%0d_data", k), 32'(b5.out_data), 32'('h50 + np_exp[k]));
        end
        b5.in_valid = '0;
        b5.in_last  = '0;
        tick();

        // Reset asserted during beat 2 of master 12's packet
        drive16(12, 1'b1, 16'h00E0, 1'b0);
        tick();
        chk("mrst_sel", 32'(b16.sel), 12);
        tick();
        chk("mrst_b1_valid", 32'(b16.out_valid), 1);
        drive16(12, 1'b1, 16'h00E1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(b16.out_valid), 0);
        chk("mrst_in_ready", 32'(b16.in_ready), 0);
        chk("mrst_grant", 32'(b16.grant_active), 0);
        chk("mrst_sel_cleared", 32'(b16.sel), 0);
        drive16(12, 1'b0, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive16(0, 1'b1, 16'h000A, 1'b1);
        drive16(9, 1'b1, 16'h009A, 1'b1);
        tick();
        chk("mrst_first_winner", 32'(b16.sel), 0);
        tick();
        chk("mrst_first_data", 32'(b16.out_data), 'h0A);
        b16.in_valid = '0;
        b16.in_last  = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
